// File: rtl/c1_dtack_watchdog.sv
// c1_dtack_watchdog: bus-cycle watchdog between the C1 wait/DTACK generator and the 68K.
// Raises nBERR when a cycle waits TIMEOUT_CYCLES enables without DTACK and records the faulting address and direction.
// Optional macro C1_BERR_STATS_EN adds an 8-bit saturating fault counter on BERR_COUNT.
module c1_dtack_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,  // legal range 2..127
  parameter int CNT_W          = 7    // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CLK_EN_68K_P,
  input  logic        nAS,
  input  logic        nDTACK_IN,
  input  logic [22:0] M68K_ADDR,
  input  logic        M68K_RW,
  input  logic        WD_ENABLE,
  input  logic        BERR_CLR,
  output logic        nBERR,
  output logic        BERR_FLAG,
  output logic [22:0] BERR_ADDR,
  output logic        BERR_RW
`ifdef C1_BERR_STATS_EN
  ,
  output logic [7:0]  BERR_COUNT
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACKED = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             fault_entry;

  // A fault starts on an enable where a still-waiting cycle has used up its budget.
  // ">=" (not "==") lets a count that ran past the limit while disarmed fault as soon as the watchdog is re-armed.
  always_comb begin
    fault_entry = CLK_EN_68K_P && (state == WAIT) && !nAS && nDTACK_IN
                  && WD_ENABLE && (count >= CNT_LIMIT);
  end

  // Cycle FSM with registered nBERR, wait counter and fault capture.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      count     <= '0;
      nBERR     <= 1'b1;
      BERR_ADDR <= '0;
      BERR_RW   <= 1'b0;
    end else if (CLK_EN_68K_P) begin
      case (state)
        IDLE: begin
          count <= '0;
          nBERR <= 1'b1;
          if (!nAS) begin
            if (!nDTACK_IN) begin
              state <= ACKED;
            end else begin
              state <= WAIT;
              count <= CNT_ONE;
            end
          end
        end
        WAIT: begin
          if (nAS) begin
            state <= IDLE;
            count <= '0;
          end else if (!nDTACK_IN) begin
            // DTACK wins over a timeout that would fire on this same enable.
            state <= ACKED;
            count <= '0;
          end else if (WD_ENABLE && (count >= CNT_LIMIT)) begin
            state     <= FAULT;
            count     <= '0;
            nBERR     <= 1'b0;
            BERR_ADDR <= M68K_ADDR;
            BERR_RW   <= M68K_RW;
          end else if (count != CNT_MAX) begin
            // Keeps counting while disarmed, but saturates so it never wraps back under the limit.
            count <= count + CNT_ONE;
          end
        end
        ACKED: begin
          if (nAS) begin
            state <= IDLE;
          end
        end
        FAULT: begin
          // Only the end of the bus cycle (or reset) releases nBERR; WD_ENABLE has no say here.
          if (nAS) begin
            state <= IDLE;
            nBERR <= 1'b1;
          end else begin
            nBERR <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          nBERR <= 1'b1;
        end
      endcase
    end
  end

  // Sticky fault flag; a new fault beats a coincident clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      BERR_FLAG <= 1'b0;
    end else if (fault_entry) begin
      BERR_FLAG <= 1'b1;
    end else if (CLK_EN_68K_P && BERR_CLR) begin
      BERR_FLAG <= 1'b0;
    end
  end

`ifdef C1_BERR_STATS_EN
  // Saturating fault counter; a fault coinciding with a clear leaves the count at 1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      BERR_COUNT <= 8'd0;
    end else if (fault_entry) begin
      if (CLK_EN_68K_P && BERR_CLR) begin
        BERR_COUNT <= 8'd1;
      end else if (BERR_COUNT != 8'hFF) begin
        BERR_COUNT <= BERR_COUNT + 8'd1;
      end
    end else if (CLK_EN_68K_P && BERR_CLR) begin
      BERR_COUNT <= 8'd0;
    end
  end
`endif

endmodule
